imem_dmem_arbiter: RTL and testbench
====================================

Name: imem_dmem_arbiter

Overview:
- Shares the single core memory port (stb/ack handshake) between the IF stage (instruction fetch, read-only) and the load/store unit (read/write with byte selects).
- Sits between the IF/MEM stages and the unified memory.
- Serialises transactions and gives load/store priority, bounded by a starvation guard for fetch.
- Cancels in-flight fetches on branch/jump redirects and aborts hung transactions with a timeout.

Parameters:
AW, 32, address width of all address ports
MAX_LS_STREAK, 4, max consecutive LS grants while an IF request is pending (must be >=1)
TIMEOUT, 64, cycles in a grant state without i_mem_ack before abort; 0 disables the timeout

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
i_if_stb  in  1  IF request; held until o_if_ack
i_if_addr  in  AW  IF fetch address
o_if_ack  out  1  IF completion pulse
o_if_rdata  out  32  fetched instruction, valid with o_if_ack
i_flush  in  1  redirect (branch taken / jalr); cancels IF traffic
i_ls_stb  in  1  LS request; held until o_ls_ack
i_ls_we  in  1  LS write enable
i_ls_sel  in  4  LS byte selects
i_ls_addr  in  AW  LS address
i_ls_wdata  in  32  LS write data
o_ls_ack  out  1  LS completion pulse
o_ls_rdata  out  32  load data, valid with o_ls_ack
o_mem_stb  out  1  memory strobe
o_mem_we  out  1  memory write enable (0 for IF)
o_mem_sel  out  4  byte selects (4'hF for IF)
o_mem_addr  out  AW  memory address
o_mem_wdata  out  32  memory write data (0 for IF)
i_mem_ack  in  1  memory completion pulse
i_mem_rdata  in  32  memory read data
o_bus_err  out  1  one-cycle timeout-abort pulse

Behaviour:
- States: IDLE, GRANT_IF, GRANT_LS. All memory-side outputs are registered. Requester acks and rdata are combinational from i_mem_ack / i_mem_rdata.
- Reset: state IDLE; o_mem_* = 0; flush flag, streak counter and timeout counter = 0. Reset asserted mid-transaction aborts it: o_mem_stb is 0 after the edge and no ack is issued.
- Grant decision in IDLE, evaluated each cycle:
  - LS wins if i_ls_stb && (!i_if_stb || streak < MAX_LS_STREAK).
  - Otherwise IF wins if i_if_stb && !i_flush.
- On a grant, the winner's address, we, sel and wdata are latched, and o_mem_stb = 1 from the next cycle. Minimum latency: request sampled at cycle N, strobe at N+1.
- Streak counter:
  - Increments on each LS grant made while i_if_stb = 1; saturates at MAX_LS_STREAK.
  - Clears on an IF grant, or when an LS grant is made with i_if_stb = 0.
- GRANT_x, on i_mem_ack:
  - o_x_ack = 1 in the same cycle; o_x_rdata = i_mem_rdata.
  - Next state IDLE; o_mem_stb = 0 the next cycle. There is always exactly one IDLE turnaround cycle between transactions.
- o_mem_stb stays asserted and the latched signals stay stable until ack or timeout. Requester inputs may change after the grant without effect.
- i_mem_ack in IDLE is ignored. o_if_ack and o_ls_ack are never asserted together.
- Flush:
  - i_flush in IDLE blocks an IF grant that cycle; an LS grant is still allowed.
  - i_flush in GRANT_IF sets the flush flag. The memory transaction runs to ack, o_if_ack is suppressed, and the flag clears on return to IDLE.
  - i_flush in GRANT_LS has no effect.
- Timeout (TIMEOUT > 0):
  - The counter runs in GRANT states and clears in IDLE.
  - When the count reaches TIMEOUT with no ack: o_bus_err = 1 and the granted requester's ack = 1 (suppressed if the flush flag is set), rdata forced to 0, o_mem_stb = 0 next cycle, next state IDLE.
  - An ack arriving in the same cycle as the timeout wins: normal completion, no error.
- When a requester sees its ack with its stb still high on the following IDLE cycle, that is a new request.
- o_if_rdata and o_ls_rdata are 0 whenever the corresponding ack is 0.

Test Plan:
- IF only, memory acks 1 cycle after strobe, addr 0x100:
  - o_mem_stb high at N+1 with o_mem_addr = 0x100, sel = F, we = 0.
  - o_if_ack at N+2 with o_if_rdata = i_mem_rdata = 0x00106293.
- Both stb high at cycle 0; LS store to 0x20, sel = 4'h3, wdata = 0xDEAD:
  - LS is granted first with o_mem_we = 1, sel = 3, wdata = 0xDEAD.
  - IF is granted after one IDLE cycle.
- LS requests continuously with IF pending, MAX_LS_STREAK = 4: grant sequence is LS, LS, LS, LS, IF, then LS resumes.
- i_flush pulsed 1 cycle after an IF grant, ack after 3 cycles: o_mem_stb held until ack, o_if_ack never asserts, next IF request granted normally.
- Memory never acks, TIMEOUT = 8: o_bus_err and o_ls_ack pulse exactly 8 cycles after stb rise, o_ls_rdata = 0, stb drops next cycle.
- rst asserted mid-GRANT_LS: after the edge o_mem_stb = 0, state IDLE, and neither o_ls_ack nor o_bus_err ever pulses for the aborted transaction.

Source files
------------

// File: rtl/imem_dmem_arbiter.sv
// Shares the single stb/ack memory port between instruction fetch and the load/store unit.
// Load/store has priority, fetch is protected from starvation, and hung transactions time out.
module imem_dmem_arbiter #(
  parameter int AW            = 32,
  parameter int MAX_LS_STREAK = 4,
  parameter int TIMEOUT       = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_if_stb,
  input  logic [AW-1:0] i_if_addr,
  output logic          o_if_ack,
  output logic [31:0]   o_if_rdata,
  input  logic          i_flush,
  input  logic          i_ls_stb,
  input  logic          i_ls_we,
  input  logic [3:0]    i_ls_sel,
  input  logic [AW-1:0] i_ls_addr,
  input  logic [31:0]   i_ls_wdata,
  output logic          o_ls_ack,
  output logic [31:0]   o_ls_rdata,
  output logic          o_mem_stb,
  output logic          o_mem_we,
  output logic [3:0]    o_mem_sel,
  output logic [AW-1:0] o_mem_addr,
  output logic [31:0]   o_mem_wdata,
  input  logic          i_mem_ack,
  input  logic [31:0]   i_mem_rdata,
  output logic          o_bus_err
);

  localparam int SW = $clog2(MAX_LS_STREAK + 1);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LS_STREAK);
  localparam logic [TW-1:0] TMO_LIMIT  = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    GRANT_IF,
    GRANT_LS
  } state_t;

  state_t        state;
  logic          flush_flag;
  logic [SW-1:0] streak;
  logic [TW-1:0] tmo_cnt;

  logic granted;
  logic timeout;
  logic done;
  logic ls_win;
  logic if_win;
  logic if_drop;

  assign granted = (state != IDLE);
  assign timeout = granted && (TIMEOUT > 0) && (tmo_cnt == TMO_LIMIT) && !i_mem_ack;
  // Acks are gated by reset so an aborted transaction can never complete in the reset cycle.
  assign done    = granted && (i_mem_ack || timeout) && !rst;

  assign ls_win  = i_ls_stb && (!i_if_stb || (streak < STREAK_MAX));
  assign if_win  = !ls_win && i_if_stb && !i_flush;
  assign if_drop = flush_flag || i_flush;

  assign o_ls_ack   = done && (state == GRANT_LS);
  assign o_if_ack   = done && (state == GRANT_IF) && !if_drop;
  assign o_ls_rdata = (o_ls_ack && i_mem_ack) ? i_mem_rdata : 32'h0;
  assign o_if_rdata = (o_if_ack && i_mem_ack) ? i_mem_rdata : 32'h0;
  assign o_bus_err  = timeout && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      o_mem_stb   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_sel   <= 4'h0;
      o_mem_addr  <= '0;
      o_mem_wdata <= 32'h0;
      flush_flag  <= 1'b0;
      streak      <= '0;
      tmo_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          tmo_cnt    <= '0;
          flush_flag <= 1'b0;
          if (ls_win) begin
            state       <= GRANT_LS;
            o_mem_stb   <= 1'b1;
            o_mem_we    <= i_ls_we;
            o_mem_sel   <= i_ls_sel;
            o_mem_addr  <= i_ls_addr;
            o_mem_wdata <= i_ls_wdata;
            // The streak only counts LS grants that actually held off a waiting fetch.
            if (!i_if_stb) begin
              streak <= '0;
            end else if (streak < STREAK_MAX) begin
              streak <= streak + 1'b1;
            end
          end else if (if_win) begin
            state       <= GRANT_IF;
            o_mem_stb   <= 1'b1;
            o_mem_we    <= 1'b0;
            o_mem_sel   <= 4'hF;
            o_mem_addr  <= i_if_addr;
            o_mem_wdata <= 32'h0;
            streak      <= '0;
          end
        end
        GRANT_IF, GRANT_LS: begin
          if (state == GRANT_IF && i_flush) begin
            flush_flag <= 1'b1;
          end
          if (i_mem_ack || timeout) begin
            state      <= IDLE;
            o_mem_stb  <= 1'b0;
            flush_flag <= 1'b0;
            tmo_cnt    <= '0;
          end else if (TIMEOUT > 0) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          o_mem_stb <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed and randomised bench for imem_dmem_arbiter, checked every cycle against a
// transaction-level model of the bus owner, its age, the fetch-starvation streak and flushes.
module tb_imem_dmem_arbiter;

  localparam int AW            = 32;
  localparam int MAX_LS_STREAK = 4;
  localparam int TIMEOUT       = 8;
  localparam int NONE          = 0;
  localparam int OWN_IF        = 1;
  localparam int OWN_LS        = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_if_stb;
  logic [AW-1:0] i_if_addr;
  logic          o_if_ack;
  logic [31:0]   o_if_rdata;
  logic          i_flush;
  logic          i_ls_stb;
  logic          i_ls_we;
  logic [3:0]    i_ls_sel;
  logic [AW-1:0] i_ls_addr;
  logic [31:0]   i_ls_wdata;
  logic          o_ls_ack;
  logic [31:0]   o_ls_rdata;
  logic          o_mem_stb;
  logic          o_mem_we;
  logic [3:0]    o_mem_sel;
  logic [AW-1:0] o_mem_addr;
  logic [31:0]   o_mem_wdata;
  logic          i_mem_ack;
  logic [31:0]   i_mem_rdata;
  logic          o_bus_err;

  always #5 clk = ~clk;

  imem_dmem_arbiter #(
    .AW(AW),
    .MAX_LS_STREAK(MAX_LS_STREAK),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_if_stb(i_if_stb),
    .i_if_addr(i_if_addr),
    .o_if_ack(o_if_ack),
    .o_if_rdata(o_if_rdata),
    .i_flush(i_flush),
    .i_ls_stb(i_ls_stb),
    .i_ls_we(i_ls_we),
    .i_ls_sel(i_ls_sel),
    .i_ls_addr(i_ls_addr),
    .i_ls_wdata(i_ls_wdata),
    .o_ls_ack(o_ls_ack),
    .o_ls_rdata(o_ls_rdata),
    .o_mem_stb(o_mem_stb),
    .o_mem_we(o_mem_we),
    .o_mem_sel(o_mem_sel),
    .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata),
    .i_mem_ack(i_mem_ack),
    .i_mem_rdata(i_mem_rdata),
    .o_bus_err(o_bus_err)
  );

  int compared   = 0;
  int mismatched = 0;
  int cycle      = 0;

  // Reference model: who owns the bus, for how long, and what it asked for.
  int          m_owner  = NONE;
  int          m_age    = 0;
  int          m_streak = 0;
  bit          m_flushed;
  bit          m_fields_known;
  logic [31:0] m_addr;
  logic        m_we;
  logic [3:0]  m_sel;
  logic [31:0] m_wdata;
  int          grant_log[$];
  int          grant_cyc[$];

  int  mem_delay  = 1;
  bit  random_mem = 1'b0;
  bit  prev_if_ack, prev_ls_ack, prev_flush;
  int  rise_cycle, err_cycle, if_ack_cycle, ls_ack_cycle;
  int  if_ack_cnt, ls_ack_cnt, err_cnt;
  logic [31:0] if_rd_seen;
  int  exp_seq[6] = '{OWN_LS, OWN_LS, OWN_LS, OWN_LS, OWN_IF, OWN_LS};

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cycle, got, exp);
    end
  endtask

  task automatic driveMem();
    i_mem_rdata = random_mem ? $urandom : 32'h0010_6293;
    if (m_owner != NONE) begin
      if (m_age == 0 && random_mem)
        mem_delay = ($urandom_range(0, 7) == 0) ? 1000 : $urandom_range(0, 3);
      i_mem_ack = (m_age == mem_delay);
    end else begin
      i_mem_ack = random_mem ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
  endtask

  // One clock cycle: settle inputs, check requester side, advance model, check memory side.
  task automatic applyStimulus();
    bit          fin, tmo, was_stb;
    logic [31:0] rd;
    logic        e_if_ack, e_ls_ack, e_err;
    logic [31:0] e_if_rd, e_ls_rd;
    driveMem();
    #1;
    e_if_ack = 1'b0; e_ls_ack = 1'b0; e_err = 1'b0;
    e_if_rd = 32'h0; e_ls_rd = 32'h0;
    fin = 1'b0; tmo = 1'b0;
    if (!rst && m_owner != NONE) begin
      fin = i_mem_ack;
      tmo = !i_mem_ack && (m_age == TIMEOUT);
      rd  = i_mem_ack ? i_mem_rdata : 32'h0;
      if (fin || tmo) begin
        if (m_owner == OWN_LS) begin
          e_ls_ack = 1'b1; e_ls_rd = rd;
        end else if (!(m_flushed || i_flush)) begin
          e_if_ack = 1'b1; e_if_rd = rd;
        end
      end
      e_err = tmo;
    end
    checkOutput("if_ack", o_if_ack, e_if_ack);
    checkOutput("if_rdata", o_if_rdata, e_if_rd);
    checkOutput("ls_ack", o_ls_ack, e_ls_ack);
    checkOutput("ls_rdata", o_ls_rdata, e_ls_rd);
    checkOutput("bus_err", o_bus_err, e_err);
    if (o_if_ack) begin if_ack_cycle = cycle; if_ack_cnt++; if_rd_seen = o_if_rdata; end
    if (o_ls_ack) begin ls_ack_cycle = cycle; ls_ack_cnt++; end
    if (o_bus_err) begin err_cycle = cycle; err_cnt++; end
    prev_if_ack = o_if_ack;
    prev_ls_ack = o_ls_ack;

    if (rst) begin
      m_owner = NONE; m_age = 0; m_streak = 0; m_flushed = 1'b0;
      m_addr = 32'h0; m_we = 1'b0; m_sel = 4'h0; m_wdata = 32'h0;
      m_fields_known = 1'b1;
    end else if (m_owner == NONE) begin
      if (i_ls_stb && (!i_if_stb || m_streak < MAX_LS_STREAK)) begin
        m_owner  = OWN_LS;
        m_streak = i_if_stb ? ((m_streak < MAX_LS_STREAK) ? m_streak + 1 : MAX_LS_STREAK) : 0;
        m_addr = i_ls_addr; m_we = i_ls_we; m_sel = i_ls_sel; m_wdata = i_ls_wdata;
      end else if (i_if_stb && !i_flush) begin
        m_owner  = OWN_IF;
        m_streak = 0;
        m_addr = i_if_addr; m_we = 1'b0; m_sel = 4'hF; m_wdata = 32'h0;
      end
      if (m_owner != NONE) begin
        m_age = 0; m_flushed = 1'b0; m_fields_known = 1'b1;
        grant_log.push_back(m_owner);
        grant_cyc.push_back(cycle);
      end
    end else begin
      if (m_owner == OWN_IF && i_flush) m_flushed = 1'b1;
      if (fin || tmo) begin
        m_owner = NONE; m_flushed = 1'b0; m_fields_known = 1'b0;
      end else begin
        m_age++;
      end
    end

    was_stb = o_mem_stb;
    @(posedge clk);
    #1;
    cycle++;
    if (!was_stb && o_mem_stb) rise_cycle = cycle;
    checkOutput("mem_stb", o_mem_stb, m_owner != NONE);
    if (m_fields_known) begin
      checkOutput("mem_addr", o_mem_addr, m_addr);
      checkOutput("mem_we", o_mem_we, m_we);
      checkOutput("mem_sel", o_mem_sel, m_sel);
      checkOutput("mem_wdata", o_mem_wdata, m_wdata);
    end
  endtask

  task automatic genRequests();
    if (!i_if_stb || prev_if_ack) begin
      i_if_stb  = ($urandom_range(0, 2) != 0);
      i_if_addr = $urandom & 32'hFFFF_FFFC;
    end else if (prev_flush && $urandom_range(0, 1) == 1) begin
      i_if_addr = $urandom & 32'hFFFF_FFFC;
    end
    if (!i_ls_stb || prev_ls_ack) begin
      i_ls_stb   = ($urandom_range(0, 3) != 0);
      i_ls_we    = 1'($urandom);
      i_ls_sel   = 4'($urandom);
      i_ls_addr  = $urandom;
      i_ls_wdata = $urandom;
    end
    prev_flush = i_flush;
    i_flush    = ($urandom_range(0, 9) == 0);
    rst        = ($urandom_range(0, 249) == 0);
  endtask

  initial begin
    rst = 1'b1; i_if_stb = 1'b0; i_if_addr = '0; i_flush = 1'b0;
    i_ls_stb = 1'b0; i_ls_we = 1'b0; i_ls_sel = 4'h0; i_ls_addr = '0; i_ls_wdata = 32'h0;
    i_mem_ack = 1'b0; i_mem_rdata = 32'h0;
    prev_flush = 1'b0; err_cycle = -1; rise_cycle = -1; if_ack_cycle = -1; ls_ack_cycle = -1;
    applyStimulus();
    applyStimulus();
    rst = 1'b0;

    $display("[TB] IF-only fetch");
    mem_delay = 1; if_ack_cycle = -1; if_rd_seen = 32'h0;
    i_if_stb = 1'b1; i_if_addr = 32'h100;
    grant_cyc.delete();
    for (int k = 0; k < 6; k++) begin
      applyStimulus();
      if (prev_if_ack) i_if_stb = 1'b0;
    end
    checkOutput("if_latency", if_ack_cycle - grant_cyc[0], 2);
    checkOutput("if_rdata_val", if_rd_seen, 32'h0010_6293);

    $display("[TB] simultaneous LS store and IF");
    grant_log.delete(); grant_cyc.delete();
    i_if_stb = 1'b1; i_if_addr = 32'h200;
    i_ls_stb = 1'b1; i_ls_we = 1'b1; i_ls_sel = 4'h3; i_ls_addr = 32'h20; i_ls_wdata = 32'hDEAD;
    for (int k = 0; k < 10; k++) begin
      applyStimulus();
      if (prev_if_ack) i_if_stb = 1'b0;
      if (prev_ls_ack) i_ls_stb = 1'b0;
    end
    checkOutput("prio_count", grant_log.size(), 2);
    checkOutput("prio_first", grant_log[0], OWN_LS);
    checkOutput("prio_second", grant_log[1], OWN_IF);
    checkOutput("turnaround", grant_cyc[1] - grant_cyc[0], 3);

    $display("[TB] LS streak against pending IF");
    grant_log.delete();
    i_if_stb = 1'b1; i_if_addr = 32'h500;
    i_ls_stb = 1'b1; i_ls_we = 1'b0; i_ls_sel = 4'hF; i_ls_addr = 32'h80;
    for (int k = 0; k < 20; k++) begin
      applyStimulus();
      if (prev_if_ack) i_if_stb = 1'b0;
    end
    i_ls_stb = 1'b0;
    for (int k = 0; k < 4; k++) applyStimulus();
    checkOutput("streak_len", grant_log.size() >= 6, 1);
    for (int k = 0; k < 6; k++) checkOutput("streak_seq", grant_log[k], exp_seq[k]);

    $display("[TB] flush during IF grant");
    mem_delay = 3; if_ack_cnt = 0;
    i_if_stb = 1'b1; i_if_addr = 32'h300;
    applyStimulus();
    i_if_addr = 32'h400; i_flush = 1'b1;
    applyStimulus();
    i_flush = 1'b0;
    for (int k = 0; k < 10 && m_owner != NONE; k++) applyStimulus();
    checkOutput("flush_done", m_owner == NONE, 1);
    checkOutput("flushed_if_acks", if_ack_cnt, 0);
    for (int k = 0; k < 10 && i_if_stb; k++) begin
      applyStimulus();
      if (prev_if_ack) i_if_stb = 1'b0;
    end
    checkOutput("refetch_acks", if_ack_cnt, 1);

    $display("[TB] hung LS load times out");
    mem_delay = 1000; err_cycle = -1; ls_ack_cycle = -1;
    i_ls_stb = 1'b1; i_ls_we = 1'b0; i_ls_addr = 32'h40;
    for (int k = 0; k < 15; k++) begin
      applyStimulus();
      if (prev_ls_ack) i_ls_stb = 1'b0;
    end
    checkOutput("tmo_delay", err_cycle - rise_cycle, TIMEOUT);
    checkOutput("tmo_ls_ack", ls_ack_cycle, err_cycle);

    $display("[TB] reset during LS grant");
    i_ls_stb = 1'b1; i_ls_we = 1'b1; i_ls_addr = 32'h60; i_ls_wdata = 32'h1;
    applyStimulus();
    i_ls_stb = 1'b0;
    applyStimulus();
    applyStimulus();
    ls_ack_cnt = 0; err_cnt = 0;
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    for (int k = 0; k < 12; k++) applyStimulus();
    checkOutput("rst_ls_acks", ls_ack_cnt, 0);
    checkOutput("rst_bus_errs", err_cnt, 0);

    $display("[TB] random traffic");
    random_mem = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      genRequests();
      applyStimulus();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
